// File: rtl/ntt_addr_gen.sv
// Kyber NTT address/twiddle sequencer: one butterfly issue per cycle over 7 layers,
// with the address pair delayed BF_LAT cycles for in-place write-back.
// Optional inverse (Gentleman-Sande) ordering is enabled by defining NTT_ADDR_GEN_INTT_EN.
module ntt_addr_gen #(
    parameter int unsigned BF_LAT = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef NTT_ADDR_GEN_INTT_EN
    input  logic              inv,
`endif
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [6:0]        tw_idx,
    output logic [2:0]        layer,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]        r_layer;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_j;
    logic [ADDR_W-1:0] r_grp;
    logic [6:0]        r_k;
    logic [6:0]        r_cnt;
    logic [3:0]        r_drain;
    logic              r_inv;

    logic              w_inv_in;
    logic              w_issue;
    logic              w_grp_end;
    logic              w_last_issue;
    logic              w_drain_last;
    logic              w_last_layer;
    logic [ADDR_W-1:0] w_grp_last;
    logic [ADDR_W-1:0] w_grp_next;
    logic [ADDR_W-1:0] w_len_fwd0;

    logic              r_sr_en [BF_LAT];
    logic [ADDR_W-1:0] r_sr_a  [BF_LAT];
    logic [ADDR_W-1:0] r_sr_b  [BF_LAT];

`ifdef NTT_ADDR_GEN_INTT_EN
    assign w_inv_in = inv;
`else
    assign w_inv_in = 1'b0;
`endif

    assign w_issue      = (r_state == S_RUN) && !stall;
    assign w_grp_last   = r_grp + r_len - ADDR_W'(1);
    assign w_grp_end    = (r_j == w_grp_last);
    assign w_grp_next   = r_grp + (r_len << 1);
    assign w_last_issue = (r_cnt == 7'd127);
    assign w_drain_last = (r_drain == 4'(BF_LAT - 1));
    assign w_last_layer = (r_layer == 3'd6);
    assign w_len_fwd0   = ADDR_W'(1) << (ADDR_W - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_issue && w_last_issue) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drain_last) w_state_nxt = w_last_layer ? S_DONE : S_RUN;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address/twiddle outputs are forced to zero on non-issue cycles so the write
    // pipeline only ever carries zeros alongside a cleared valid bit.
    always_comb begin
        rd_en     = w_issue;
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_idx    = '0;
        if (w_issue) begin
            rd_addr_a = r_j;
            rd_addr_b = r_j + r_len;
            tw_idx    = r_k;
        end
        layer = r_layer;
        busy  = (r_state != S_IDLE);
        done  = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layer <= '0;
            r_len   <= '0;
            r_j     <= '0;
            r_grp   <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_inv   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_layer <= '0;
                        r_len   <= w_inv_in ? ADDR_W'(2) : w_len_fwd0;
                        r_j     <= '0;
                        r_grp   <= '0;
                        r_k     <= w_inv_in ? 7'd127 : 7'd1;
                        r_cnt   <= '0;
                        r_drain <= '0;
                        r_inv   <= w_inv_in;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_cnt <= r_cnt + 7'd1;
                        if (w_grp_end) begin
                            r_grp <= w_grp_next;
                            r_j   <= w_grp_next;
                            r_k   <= r_inv ? (r_k - 7'd1) : (r_k + 7'd1);
                        end else begin
                            r_j <= r_j + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain + 4'd1;
                    if (w_drain_last) begin
                        r_drain <= '0;
                        if (!w_last_layer) begin
                            r_layer <= r_layer + 3'd1;
                            r_len   <= r_inv ? (r_len << 1) : (r_len >> 1);
                            r_j     <= '0;
                            r_grp   <= '0;
                        end
                    end
                end
                S_DONE: begin
                    r_layer <= '0;
                    r_len   <= '0;
                    r_j     <= '0;
                    r_grp   <= '0;
                    r_k     <= '0;
                    r_cnt   <= '0;
                    r_inv   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Free-running write-back delay line; deliberately not gated by stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BF_LAT; i++) begin
                r_sr_en[i] <= 1'b0;
                r_sr_a[i]  <= '0;
                r_sr_b[i]  <= '0;
            end
        end else begin
            r_sr_en[0] <= rd_en;
            r_sr_a[0]  <= rd_addr_a;
            r_sr_b[0]  <= rd_addr_b;
            for (int unsigned i = 1; i < BF_LAT; i++) begin
                r_sr_en[i] <= r_sr_en[i-1];
                r_sr_a[i]  <= r_sr_a[i-1];
                r_sr_b[i]  <= r_sr_b[i-1];
            end
        end
    end

    assign wr_en     = r_sr_en[BF_LAT-1];
    assign wr_addr_a = r_sr_a[BF_LAT-1];
    assign wr_addr_b = r_sr_b[BF_LAT-1];

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Self-checking bench for ntt_addr_gen: butterfly order and cycle schedule are
// generated from the layer/group rules and compared cycle by cycle.
`timescale 1ns/1ps
module tb_ntt_addr_gen;

    localparam int unsigned BF_LAT = 4;
    localparam int unsigned ADDR_W = 8;
    localparam int MAXC = 2048;
    localparam int NISS = 896;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stall = 1'b0;
    logic              inv = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [6:0]        tw_idx;
    logic [2:0]        layer;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [ADDR_W-1:0] wr_addr_b;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    int iss_a [NISS];
    int iss_b [NISS];
    int iss_k [NISS];
    int iss_l [NISS];

    bit stall_pat [MAXC];
    bit e_rd      [MAXC];
    bit e_wr      [MAXC];
    int e_rd_idx  [MAXC];
    int e_wr_idx  [MAXC];
    int exp_done_cyc;

    bit obs_rd [MAXC];
    int obs_a  [MAXC];
    int obs_b  [MAXC];
    int obs_tw [MAXC];
    int obs_done_at;
    int obs_n_done;
    int obs_n_wr;

    ntt_addr_gen #(
        .BF_LAT(BF_LAT),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef NTT_ADDR_GEN_INTT_EN
        .inv      (inv),
`endif
        .stall    (stall),
        .rd_en    (rd_en),
        .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b),
        .tw_idx   (tw_idx),
        .layer    (layer),
        .wr_en    (wr_en),
        .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Butterfly list straight from the CT / GS loop nests, then a cycle schedule:
    // each issue takes the next non-stalled cycle, each layer ends with BF_LAT drain cycles.
    task automatic build_model(input bit inv_i);
        int n;
        int k;
        int len;
        int t;
        n = 0;
        k = inv_i ? 127 : 1;
        for (int l = 0; l < 7; l++) begin
            len = inv_i ? (2 << l) : (128 >> l);
            for (int s = 0; s < 256; s += 2 * len) begin
                for (int j = s; j < s + len; j++) begin
                    iss_a[n] = j;
                    iss_b[n] = j + len;
                    iss_k[n] = k;
                    iss_l[n] = l;
                    n++;
                end
                k = inv_i ? k - 1 : k + 1;
            end
        end
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 1'b0;
            e_wr[c] = 1'b0;
            e_rd_idx[c] = 0;
            e_wr_idx[c] = 0;
        end
        t = 1;
        for (int i = 0; i < NISS; i++) begin
            while (stall_pat[t]) t++;
            e_rd[t] = 1'b1;
            e_rd_idx[t] = i;
            e_wr[t + BF_LAT] = 1'b1;
            e_wr_idx[t + BF_LAT] = i;
            t++;
            if (i % 128 == 127) t += BF_LAT;
        end
        exp_done_cyc = t;
    endtask

    // stall_mode: 0 none, 1 random, 2 three cycles right after the a=5 issue.
    task automatic run_transform(input bit inv_i, input int stall_mode, input bit start_noise);
        int i;
        for (int c = 0; c < MAXC; c++) begin
            stall_pat[c] = 1'b0;
            if (stall_mode == 1 && c < 1400) stall_pat[c] = ($urandom_range(0, 7) == 0);
        end
        if (stall_mode == 2) begin
            stall_pat[7] = 1'b1;
            stall_pat[8] = 1'b1;
            stall_pat[9] = 1'b1;
        end
        build_model(inv_i);
        obs_done_at = -1;
        obs_n_done = 0;
        obs_n_wr = 0;

        @(posedge clk);
        #1;
        start = 1'b1;
        inv = inv_i;
        stall = stall_pat[0];
        for (int c = 0; c <= exp_done_cyc + int'(BF_LAT) + 3; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
                start = start_noise && c >= 2 && c < exp_done_cyc &&
                        (c == 450 || $urandom_range(0, 15) == 0);
                inv = start ? ~inv_i : inv_i;
                stall = stall_pat[c];
            end
            @(negedge clk);
            obs_rd[c] = rd_en;
            obs_a[c]  = int'(rd_addr_a);
            obs_b[c]  = int'(rd_addr_b);
            obs_tw[c] = int'(tw_idx);
            if (done === 1'b1) begin
                obs_n_done++;
                if (obs_done_at < 0) obs_done_at = c;
            end
            if (wr_en === 1'b1) obs_n_wr++;

            checks++;
            if (rd_en !== e_rd[c]) begin
                errors++;
                $display("FAIL rd_en cycle %0d: got %b expected %b", c, rd_en, e_rd[c]);
            end
            if (e_rd[c]) begin
                i = e_rd_idx[c];
                checks++;
                if (rd_addr_a !== 8'(iss_a[i]) || rd_addr_b !== 8'(iss_b[i]) ||
                    tw_idx !== 7'(iss_k[i]) || layer !== 3'(iss_l[i])) begin
                    errors++;
                    $display("FAIL rd_issue cycle %0d: got a=%0d b=%0d tw=%0d L=%0d expected a=%0d b=%0d tw=%0d L=%0d",
                             c, rd_addr_a, rd_addr_b, tw_idx, layer, iss_a[i], iss_b[i], iss_k[i], iss_l[i]);
                end
            end
            checks++;
            if (wr_en !== e_wr[c]) begin
                errors++;
                $display("FAIL wr_en cycle %0d: got %b expected %b", c, wr_en, e_wr[c]);
            end
            if (e_wr[c]) begin
                i = e_wr_idx[c];
                checks++;
                if (wr_addr_a !== 8'(iss_a[i]) || wr_addr_b !== 8'(iss_b[i])) begin
                    errors++;
                    $display("FAIL wr_addr cycle %0d: got a=%0d b=%0d expected a=%0d b=%0d",
                             c, wr_addr_a, wr_addr_b, iss_a[i], iss_b[i]);
                end
            end
            checks++;
            if (done !== (c == exp_done_cyc) || busy !== (c >= 1 && c <= exp_done_cyc)) begin
                errors++;
                $display("FAIL done_busy cycle %0d: got done=%b busy=%b expected done=%b busy=%b",
                         c, done, busy, (c == exp_done_cyc), (c >= 1 && c <= exp_done_cyc));
            end
        end
        start = 1'b0;
        stall = 1'b0;
        inv = 1'b0;

        checks++;
        if (obs_n_wr != NISS) begin
            errors++;
            $display("FAIL wr_count: got %0d expected %0d", obs_n_wr, NISS);
        end
        checks++;
        if (obs_n_done != 1) begin
            errors++;
            $display("FAIL done_count: got %0d expected 1", obs_n_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({rd_en, rd_addr_a, rd_addr_b, tw_idx, layer, wr_en, wr_addr_a, wr_addr_b, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs (rd_en=%b busy=%b wr_en=%b) expected all 0",
                     rd_en, busy, wr_en);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b rd_en=%b expected 0 0", busy, rd_en);
        end
    endtask

    task automatic test_forward();
        int tbl [6][4] = '{'{1, 0, 128, 1}, '{128, 127, 255, 1}, '{133, 0, 64, 2},
                           '{197, 128, 192, 3}, '{793, 0, 2, 64}, '{920, 253, 255, 127}};
        run_transform(1'b0, 0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            checks++;
            if (!obs_rd[tbl[r][0]] || obs_a[tbl[r][0]] != tbl[r][1] ||
                obs_b[tbl[r][0]] != tbl[r][2] || obs_tw[tbl[r][0]] != tbl[r][3]) begin
                errors++;
                $display("FAIL fwd_spot cycle %0d: got rd=%b a=%0d b=%0d tw=%0d expected rd=1 a=%0d b=%0d tw=%0d",
                         tbl[r][0], obs_rd[tbl[r][0]], obs_a[tbl[r][0]], obs_b[tbl[r][0]],
                         obs_tw[tbl[r][0]], tbl[r][1], tbl[r][2], tbl[r][3]);
            end
        end
        for (int c = 129; c <= 132; c++) begin
            checks++;
            if (obs_rd[c]) begin
                errors++;
                $display("FAIL fwd_drain cycle %0d: got rd_en=1 expected 0", c);
            end
        end
        checks++;
        if (obs_done_at != 925) begin
            errors++;
            $display("FAIL fwd_done_cycle: got %0d expected 925", obs_done_at);
        end
    endtask

    task automatic test_stall_directed();
        run_transform(1'b0, 2, 1'b0);
        for (int c = 7; c <= 9; c++) begin
            checks++;
            if (obs_rd[c]) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got rd_en=1 expected 0", c);
            end
        end
        checks++;
        if (!obs_rd[10] || obs_a[10] != 6 || obs_b[10] != 134 || obs_tw[10] != 1) begin
            errors++;
            $display("FAIL stall_resume: got rd=%b a=%0d b=%0d tw=%0d expected rd=1 a=6 b=134 tw=1",
                     obs_rd[10], obs_a[10], obs_b[10], obs_tw[10]);
        end
        checks++;
        if (obs_done_at != 928) begin
            errors++;
            $display("FAIL stall_done_cycle: got %0d expected 928", obs_done_at);
        end
    endtask

    task automatic test_random_stall_start_noise();
        run_transform(1'b0, 1, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_transform(1'b0, 1, 1'b0);
        run_transform(1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_layer();
        @(posedge clk);
        #1;
        start = 1'b1;
        inv = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        checks++;
        if (rd_en !== 1'b1 || layer !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset_layer: got rd_en=%b layer=%0d expected 1 2", rd_en, layer);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_en, rd_addr_a, rd_addr_b, tw_idx, layer, wr_en, wr_addr_a, wr_addr_b, busy, done} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rd_en=%b layer=%0d wr_en=%b busy=%b expected all 0",
                     rd_en, layer, wr_en, busy);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset cycle %0d: got wr_en=%b rd_en=%b busy=%b expected 0 0 0",
                         c, wr_en, rd_en, busy);
            end
        end
    endtask

`ifdef NTT_ADDR_GEN_INTT_EN
    task automatic test_inverse();
        int tbl [3][4] = '{'{1, 0, 2, 127}, '{3, 4, 6, 126}, '{920, 127, 255, 1}};
        run_transform(1'b1, 0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            checks++;
            if (!obs_rd[tbl[r][0]] || obs_a[tbl[r][0]] != tbl[r][1] ||
                obs_b[tbl[r][0]] != tbl[r][2] || obs_tw[tbl[r][0]] != tbl[r][3]) begin
                errors++;
                $display("FAIL inv_spot cycle %0d: got rd=%b a=%0d b=%0d tw=%0d expected rd=1 a=%0d b=%0d tw=%0d",
                         tbl[r][0], obs_rd[tbl[r][0]], obs_a[tbl[r][0]], obs_b[tbl[r][0]],
                         obs_tw[tbl[r][0]], tbl[r][1], tbl[r][2], tbl[r][3]);
            end
        end
        run_transform(1'b1, 1, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_stall_directed();
        test_random_stall_start_noise();
        test_back_to_back();
        test_reset_mid_layer();
        test_forward();
`ifdef NTT_ADDR_GEN_INTT_EN
        test_inverse();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_addr_gen.md
Name: ntt_addr_gen

Overview:
- Address/twiddle sequencer sitting directly upstream of the modular butterfly stage in the Kyber NTT pipeline (q=3329, N=256).
- Walks the 7 Cooley-Tukey layers, issuing one butterfly per cycle:
  - read address pair (a, b) to the coefficient RAM;
  - twiddle ROM index for wn.
- Delays the address pair by the butterfly latency so results c/d can be written back in place.
- Inserts a drain gap between layers so no read overtakes a pending write.

Parameters:
- BF_LAT, 4: butterfly pipeline depth in cycles, from rd_en to valid c/d; legal range 1..15.
- ADDR_W, 8: coefficient address width (N = 2^ADDR_W = 256); fixed for Kyber.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a transform; sampled only in IDLE.
- stall  input  1  1 = hold issue this cycle (RAM port busy).
- rd_en  output  1  valid butterfly issue this cycle.
- rd_addr_a  output  ADDR_W  address of operand a (index j).
- rd_addr_b  output  ADDR_W  address of operand b (index j+len).
- tw_idx  output  7  twiddle ROM index k.
- layer  output  3  current layer 0..6.
- wr_en  output  1  write-back strobe, rd_en delayed BF_LAT cycles.
- wr_addr_a  output  ADDR_W  write address for c = a + b*wn.
- wr_addr_b  output  ADDR_W  write address for d = a - b*wn.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at transform completion.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, write-delay shift register cleared. The same holds for reset asserted mid-transform; no partial writes may emerge after reset release.
- States: IDLE -> RUN -> DRAIN -> (RUN of next layer | DONE) -> IDLE.
- IDLE:
  - start=1 -> RUN next cycle with layer=0, len=128, j=0, k=1.
  - start is ignored in any other state.
- RUN:
  - If stall=0: rd_en=1, rd_addr_a=j, rd_addr_b=j+len, tw_idx=k, then advance the counters.
  - If stall=1: rd_en=0 and all counters hold.
  - Within a group, j increments. At the group end (j = start+len-1), start += 2*len, j = new start, k++.
  - After 128 issues in the layer -> DRAIN.
- Ordering: for len = 128,64,...,2 (layer 0..6), start steps by 2*len, k increments once per group starting at 1. Layer L therefore uses k = 2^L .. 2^(L+1)-1.
- DRAIN:
  - rd_en=0 for exactly BF_LAT cycles, counted unconditionally; stall is ignored here.
  - Then, if layer<6: layer++, len>>=1, j=0, back to RUN.
  - Otherwise go to DONE.
- DONE: done=1 for one cycle, busy still 1; -> IDLE.
- Write path:
  - Shift register of depth BF_LAT carrying {rd_en, rd_addr_a, rd_addr_b}.
  - It advances every cycle regardless of stall, so wr_* equals rd_* delayed exactly BF_LAT cycles.
- Timing with no stalls: start seen at cycle 0, first rd_en at cycle 1. Layer L issues occupy cycles 1+L*(128+BF_LAT) .. 128+L*(128+BF_LAT).
- The last wr_en coincides with the last DRAIN cycle. done asserts on the following cycle: cycle 925 for BF_LAT=4.
- Stalls extend the RUN cycles 1:1 and never drop or duplicate an issue.
- Arithmetic: j+len is computed in ADDR_W bits and never wraps (maximum 255). k is 7 bits, with maximum 127 in the last group.

Optional Feature:
- Macro: NTT_ADDR_GEN_INTT_EN.
- When defined:
  - An extra input port inv (1 bit) is added, sampled with start.
  - inv=1 runs the Gentleman-Sande inverse ordering: len = 2,4,...,128 for layer 0..6, with k starting at 127 and decrementing once per group.
  - Layer timing, drain and write path are identical to the forward order.
  - inv=0 gives the forward order.
- When undefined: no inv port; forward order only.

Test Plan:
- Reset, then start pulse with no stall:
  - cycle 1: rd_addr_a=0, rd_addr_b=128, tw_idx=1;
  - cycle 128: a=127, b=255, tw=1;
  - no rd_en on cycles 129..132.
  - layer 1 first issue: a=0, b=64, tw=2; its 65th issue: a=128, b=192, tw=3.
  - layer 6 first issue: a=0, b=2, tw=64; last issue: a=253, b=255, tw=127.
  - done pulses exactly once, at cycle 925.
- Write path: every wr_en/wr_addr pair equals the rd pair BF_LAT=4 cycles earlier; exactly 896 wr_en pulses in total.
- stall high for 3 cycles after issue a=5, b=133: no rd_en during the stall; next issue is a=6, b=134, tw=1; done is delayed to cycle 928.
- start asserted while busy mid-layer-3: sequence unchanged. rst_n low during layer 2: all outputs 0 immediately, no wr_en after release; a fresh start restarts at a=0, b=128.
- With NTT_ADDR_GEN_INTT_EN and inv=1:
  - first issue a=0, b=2, tw=127; issue 3: a=4, b=6, tw=126;
  - last layer issues all have tw=1, with the final issue a=127, b=255.
